// File: rtl/aes256_result_unloader_if.sv
// rtl/aes256_result_unloader_if.sv - byte-serial ciphertext input and reassembled block output bundle
interface aes256_result_unloader_if #(
  parameter int NUM_BYTES = 16
);
  logic                   pi_enc_done;
  logic                   po_next_val_req;
  logic                   pi_next_val_ready;
  logic [7:0]             pi_data;
  logic [8*NUM_BYTES-1:0] po_block;
  logic                   po_block_valid;
  logic                   pi_block_ready;
  logic                   po_busy;
  logic                   po_timeout_err;
  logic                   po_overrun_err;

  // Unloader side: consumes the byte stream, produces the block
  modport master (
    input  pi_enc_done, pi_next_val_ready, pi_data, pi_block_ready,
    output po_next_val_req, po_block, po_block_valid, po_busy,
           po_timeout_err, po_overrun_err
  );

  // Environment side: AES core / loader plus the block sink
  modport slave (
    output pi_enc_done, pi_next_val_ready, pi_data, pi_block_ready,
    input  po_next_val_req, po_block, po_block_valid, po_busy,
           po_timeout_err, po_overrun_err
  );
endinterface

// File: rtl/aes256_result_unloader.sv
// rtl/aes256_result_unloader.sv - pulls AES ciphertext byte by byte and presents it as one block
module aes256_result_unloader #(
  parameter int NUM_BYTES      = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  aes256_result_unloader_if.master  bus
);
  localparam int W     = 8 * NUM_BYTES;
  localparam int CNT_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NUM_BYTES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, OUT} state_e;

  state_e             state_q, state_d;
  logic [W-1:0]       shreg_q, shreg_d;
  logic [W-1:0]       block_q, block_d;
  logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic               valid_q, valid_d;
  logic               req_q, req_d;
  logic               busy_q, busy_d;
  logic               timeout_q, timeout_d;
  logic               overrun_q, overrun_d;

  // Next-state and registered-output logic; req/valid/busy are decided one cycle ahead
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    block_d    = block_q;
    byte_cnt_d = byte_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    valid_d    = valid_q;
    req_d      = 1'b0;
    timeout_d  = timeout_q;
    overrun_d  = overrun_q | (bus.pi_enc_done && (state_q != IDLE));

    case (state_q)
      IDLE: begin
        if (bus.pi_enc_done) begin
          state_d    = REQ;
          shreg_d    = '0;
          byte_cnt_d = '0;
          req_d      = 1'b1;
        end
      end
      REQ: begin
        // Ready seen here belongs to no request and is dropped
        tmo_cnt_d = '0;
        state_d   = WAIT;
      end
      WAIT: begin
        if (bus.pi_next_val_ready) begin
          shreg_d = {shreg_q[W-9:0], bus.pi_data};
          if (byte_cnt_q == LAST_BYTE) begin
            // Counter holds at the last index rather than wrapping
            state_d = OUT;
            block_d = {shreg_q[W-9:0], bus.pi_data};
            valid_d = 1'b1;
          end else begin
            byte_cnt_d = byte_cnt_q + CNT_W'(1);
            state_d    = REQ;
            req_d      = 1'b1;
          end
        end else if (tmo_cnt_q == TMO_LAST) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end
      OUT: begin
        if (bus.pi_block_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // Single state register; reset discards any partially collected block
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      block_q    <= '0;
      byte_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      valid_q    <= 1'b0;
      req_q      <= 1'b0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      block_q    <= block_d;
      byte_cnt_q <= byte_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      valid_q    <= valid_d;
      req_q      <= req_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
      overrun_q  <= overrun_d;
    end
  end

  assign bus.po_next_val_req = req_q;
  assign bus.po_block        = block_q;
  assign bus.po_block_valid  = valid_q;
  assign bus.po_busy         = busy_q;
  assign bus.po_timeout_err  = timeout_q;
  assign bus.po_overrun_err  = overrun_q;
endmodule

// File: tb/tb_aes256_result_unloader.sv
// tb/tb_aes256_result_unloader.sv - scoreboard bench for aes256_result_unloader
module tb_aes256_result_unloader;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  aes256_result_unloader_if #(.NUM_BYTES(16)) bus ();

  aes256_result_unloader #(.NUM_BYTES(16), .TIMEOUT_CYCLES(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [127:0] exp_q[$];
  logic [127:0] ld_blk = '0;
  int           ld_idx = 0;
  int           ld_withhold = 1000;
  int           ld_max_delay = 0;
  bit           ld_spur = 1'b0;
  logic         ld_ready = 1'b0;
  logic [7:0]   ld_data = '0;
  logic         sp_ready = 1'b0;
  logic [7:0]   sp_data = '0;
  int           req_cnt = 0;
  int           t_valid = 0;
  int           t0 = 0;
  logic         valid_prev = 1'b0;

  assign bus.pi_next_val_ready = ld_ready | sp_ready;
  assign bus.pi_data           = ld_ready ? ld_data : sp_data;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Loader model: answers each request with the next byte after 0..ld_max_delay idle cycles
  initial begin : loader
    int d;
    forever begin
      @(negedge clk);
      if (rst && bus.po_next_val_req && ld_idx < ld_withhold) begin
        d = (ld_max_delay == 0) ? 0 : int'($urandom_range(ld_max_delay, 0));
        if (ld_spur) begin
          ld_ready = 1'b1;
          ld_data  = 8'hA5;
        end
        @(posedge clk); #1;
        if (d > 0) begin
          ld_ready = 1'b0;
          repeat (d) @(posedge clk);
          #1;
        end
        ld_ready = 1'b1;
        ld_data  = ld_blk[127 - 8*ld_idx -: 8];
        @(posedge clk); #1;
        ld_ready = 1'b0;
        ld_idx++;
      end
    end
  end

  // Monitor: pops the scoreboard on every completed block handshake
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (bus.po_next_val_req) req_cnt++;
      if (bus.po_block_valid && !valid_prev) t_valid = cyc;
      valid_prev = bus.po_block_valid;
      if (rst && bus.po_block_valid && bus.pi_block_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_block: got %h expected none", bus.po_block);
        end else begin
          check("block", bus.po_block, exp_q.pop_front());
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic start_block(input logic [127:0] blk, input bit expect_out);
    @(posedge clk); #1;
    ld_blk = blk;
    ld_idx = 0;
    if (expect_out) exp_q.push_back(blk);
    bus.pi_enc_done = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    bus.pi_enc_done = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.po_busy && n < 2000);
    check(name, {127'd0, bus.po_busy}, 128'd0);
  endtask

  task automatic wait_bytes(input int k);
    int n = 0;
    while (ld_idx < k && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("wait_bytes", ld_idx, k);
  endtask

  initial begin : main
    int n;
    int t_req;
    bus.pi_enc_done    = 1'b0;
    bus.pi_block_ready = 1'b0;

    // 1: reset held with random inputs
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      bus.pi_enc_done    = 1'($urandom);
      bus.pi_block_ready = 1'($urandom);
      sp_ready           = 1'($urandom);
      sp_data            = 8'($urandom);
      @(negedge clk);
      check("rst_block", bus.po_block, 128'd0);
      check("rst_flags", {123'd0, bus.po_block_valid, bus.po_next_val_req, bus.po_busy,
                          bus.po_timeout_err, bus.po_overrun_err}, 128'd0);
    end
    @(posedge clk); #1;
    bus.pi_enc_done    = 1'b0;
    bus.pi_block_ready = 1'b1;
    sp_ready           = 1'b0;
    rst                = 1'b1;

    // 2: nominal zero-wait transfer
    req_cnt = 0;
    start_block(128'h00112233_44556677_8899AABB_CCDDEEFF, 1'b1);
    wait_idle("nominal_idle");
    check("nominal_latency", t_valid - t0, 128'd33);
    check("nominal_reqs", req_cnt, 128'd16);
    check("nominal_no_errs", {126'd0, bus.po_timeout_err, bus.po_overrun_err}, 128'd0);

    // 4: timeout after five bytes, then recovery
    ld_withhold = 5;
    start_block(128'hDEADBEEF_00000000_11111111_22222222, 1'b0);
    wait_bytes(5);
    n = 0;
    while (!bus.po_next_val_req && n < 50) begin @(negedge clk); n++; end
    t_req = cyc;
    n = 0;
    while (!bus.po_timeout_err && n < 200) begin @(negedge clk); n++; end
    check("timeout_cycles", cyc - t_req, 128'd65);
    check("timeout_busy", {126'd0, bus.po_busy, bus.po_timeout_err}, 128'd1);
    ld_withhold = 1000;
    start_block(128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0, 1'b1);
    wait_idle("timeout_recover_idle");
    check("overrun_clear", {127'd0, bus.po_overrun_err}, 128'd0);

    // 5a: enc_done mid-transfer
    start_block(128'h13579BDF_2468ACE0_FEDCBA98_76543210, 1'b1);
    wait_bytes(3);
    @(posedge clk); #1;
    bus.pi_enc_done = 1'b1;
    @(posedge clk); #1;
    bus.pi_enc_done = 1'b0;
    wait_idle("overrun_idle");
    check("overrun_flags", {126'd0, bus.po_timeout_err, bus.po_overrun_err}, 128'd3);

    // 5b: unsolicited ready in IDLE and in every REQ cycle
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      sp_ready = 1'b1;
      sp_data  = 8'h5A + 8'(i);
      @(negedge clk);
      check("spur_idle_busy", {127'd0, bus.po_busy}, 128'd0);
    end
    @(posedge clk); #1;
    sp_ready = 1'b0;
    ld_spur  = 1'b1;
    start_block(128'hA1B2C3D4_E5F60718_293A4B5C_6D7E8F90, 1'b1);
    wait_idle("spur_req_idle");
    ld_spur = 1'b0;

    // 3: random byte delays and downstream backpressure
    ld_max_delay = 10;
    bus.pi_block_ready = 1'b0;
    start_block(128'hCAFEBABE_01234567_89ABCDEF_FACEB00C, 1'b1);
    n = 0;
    while (!bus.po_block_valid && n < 2000) begin @(negedge clk); n++; end
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check("bp_hold", {127'd0, bus.po_block_valid}, 128'd1);
      check("bp_block", bus.po_block, 128'hCAFEBABE_01234567_89ABCDEF_FACEB00C);
    end
    @(posedge clk); #1;
    bus.pi_block_ready = 1'b1;
    @(posedge clk); #1;
    bus.pi_block_ready = 1'b0;
    @(negedge clk);
    check("bp_after", {126'd0, bus.po_busy, bus.po_block_valid}, 128'd0);
    bus.pi_block_ready = 1'b1;
    ld_max_delay = 0;

    // 6: reset in the middle of a transfer
    start_block(128'h99999999_88888888_77777777_66666666, 1'b0);
    wait_bytes(9);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("midrst_block", bus.po_block, 128'd0);
    check("midrst_flags", {123'd0, bus.po_block_valid, bus.po_next_val_req, bus.po_busy,
                           bus.po_timeout_err, bus.po_overrun_err}, 128'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    req_cnt = 0;
    start_block(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 1'b1);
    wait_idle("midrst_recover_idle");
    check("midrst_reqs", req_cnt, 128'd16);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 128'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
